uart_imem_loader: RTL and testbench
===================================

Name: uart_imem_loader

Overview:
Converts the UART receiver's byte stream into full-width instruction-memory write transactions, so a program can be loaded over the serial line before the core is released.
- Assembles NBYTES bytes per word, least-significant byte first, and writes each word to consecutive addresses.
- Detects an end-of-program marker sequence and raises write_done.
- Adds an inter-byte timeout, BREAK abort and overflow detection, none of which the single-width fixed loader has.

Parameters:
NBYTES, 4, bytes per memory word; word width is 8*NBYTES; legal range 1..8
ADDR_W, 8, memory address width (word addressing)
DEPTH, 256, number of words available; must be <= 2**ADDR_W
END_WORD, all-ones (8*NBYTES bits), end-of-program marker value
END_COUNT, 2, number of consecutive END_WORD words that terminate loading; legal range 1..15
TIMEOUT, 65535, clk cycles allowed between bytes of one word before the partial word is discarded

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
load_en  in  1  level; high = loading permitted; low = return to IDLE
rx_valid  in  1  one-cycle strobe: rx_data holds a new byte
rx_data  in  8  received byte
rx_break  in  1  one-cycle strobe: BREAK detected on the line
mem_we  out  1  one-cycle write strobe to instruction memory
mem_addr  out  ADDR_W  word address for mem_we
mem_wdata  out  8*NBYTES  assembled word for mem_we
busy  out  1  high in LOAD while a partial word is held
write_done  out  1  high in DONE
word_count  out  ADDR_W+1  number of words written since the load started
err_timeout  out  1  sticky: a partial word was discarded because of timeout
err_overflow  out  1  sticky: a word arrived while word_count == DEPTH

Behaviour:
- Reset (rst=1 at a clk edge):
  - State = IDLE.
  - All outputs = 0; byte index, marker count and timeout counter = 0.
  - rst takes effect mid-load; the partial word is lost.
- States:
  - IDLE: outputs hold their last values. load_en=1 -> LOAD, which clears word_count, the address, both error flags, byte index and marker count.
  - LOAD: bytes are accepted on rx_valid. The transition to DONE happens on the cycle the final marker word's mem_we is issued.
  - DONE: write_done=1; rx_valid is ignored.
  - Any state with load_en=0 -> IDLE next cycle; write_done drops; errors and word_count are retained.
- Byte assembly:
  - Byte k of a word (k = 0..NBYTES-1) goes to mem_wdata bits [8k+7:8k].
  - On the rx_valid that carries byte NBYTES-1: mem_we=1 on the NEXT cycle, with mem_addr = word_count (pre-increment) and the full word. word_count increments in the same cycle as mem_we.
  - mem_we is never high for two consecutive cycles unless NBYTES=1 and rx_valid is asserted back-to-back; that case must be supported, at one write per cycle.
  - mem_wdata and mem_addr are held stable between writes.
- busy = 1 while the byte index is nonzero.
- Marker detection:
  - Each completed word equal to END_WORD increments the marker count; any other word clears it.
  - When the count reaches END_COUNT, enter DONE.
  - Marker words ARE written to memory.
- Timeout:
  - The counter runs only while busy, and reloads on every rx_valid.
  - Reaching TIMEOUT discards the partial word: byte index = 0, err_timeout = 1. No write occurs and the marker count is unchanged.
- rx_break in LOAD: discards the partial word and clears the marker count; no error flag is set. If rx_break and rx_valid occur in the same cycle, the break wins and the byte is dropped.
- Overflow:
  - A completed word with word_count == DEPTH is not written, and err_overflow = 1.
  - Marker counting still applies, so loading can still terminate.
  - The address never wraps.
- load_en falling mid-word: the partial word is discarded.

Test Plan:
- NBYTES=4: send bytes 13 01 01 FB -> exactly one mem_we, at addr 0, data 0xFB010113, one cycle after the 4th rx_valid; word_count=1.
- Send 3 program words, then FFFFFFFF twice -> 5 writes at addr 0..4; write_done=1 in the same cycle as the 5th mem_we; a further rx_valid causes no write.
- Send FFFFFFFF, 00000013, FFFFFFFF -> marker count resets on the middle word; write_done stays 0.
- TIMEOUT=100: send 2 bytes, idle 100 cycles -> err_timeout=1, busy=0, no write; the next 4 bytes are written at the original address.
- DEPTH=4, send 5 non-marker words -> 4 writes (addr 0..3), err_overflow=1, the 5th is not written; rst -> all outputs 0.
- NBYTES=1: back-to-back rx_valid 0xAA, 0xBB -> mem_we high on 2 consecutive cycles, addr 0 then 1; rx_break together with rx_valid -> that byte is dropped.

Source files
------------

// File: rtl/uart_imem_loader.sv
// Packs the UART byte stream into NBYTES-wide instruction-memory writes and stops
// after END_COUNT consecutive END_WORD words; also handles timeout, BREAK and overflow.
module uart_imem_loader #(
  parameter int NBYTES = 4,
  parameter int ADDR_W = 8,
  parameter int DEPTH = 256,
  parameter logic [8*NBYTES-1:0] END_WORD = '1,
  parameter int END_COUNT = 2,
  parameter int TIMEOUT = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_en,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  input  logic                  rx_break,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [8*NBYTES-1:0]   mem_wdata,
  output logic                  busy,
  output logic                  write_done,
  output logic [ADDR_W:0]       word_count,
  output logic                  err_timeout,
  output logic                  err_overflow
);
  localparam int W = 8 * NBYTES;
  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [3:0] END_CNT = 4'(END_COUNT);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t state, state_nxt;
  logic [IDX_W-1:0] byte_idx;
  logic [3:0] marker_cnt;
  logic [TO_W-1:0] to_cnt;
  logic [W-1:0] word_buf, word_full;
  logic take_byte, word_end, is_marker, final_marker, timed_out;

  // Current partial word with the incoming byte dropped into its lane.
  always_comb begin
    word_full = word_buf;
    for (int k = 0; k < NBYTES; k++)
      if (byte_idx == IDX_W'(k)) word_full[8*k +: 8] = rx_data;
  end

  assign take_byte = (state == LOAD) && load_en && rx_valid && !rx_break;
  assign word_end = take_byte && (byte_idx == LAST_IDX);
  assign is_marker = (word_full == END_WORD);
  assign final_marker = word_end && is_marker && ((marker_cnt + 4'd1) == END_CNT);
  assign timed_out = (state == LOAD) && load_en && busy && !rx_valid && !rx_break &&
                     (to_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load_en) state_nxt = LOAD;
      LOAD:    if (!load_en) state_nxt = IDLE;
               else if (final_marker) state_nxt = DONE;
      DONE:    if (!load_en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    write_done = (state == DONE);
    busy = (state == LOAD) && (byte_idx != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      word_count   <= '0;
      err_timeout  <= 1'b0;
      err_overflow <= 1'b0;
      byte_idx     <= '0;
      marker_cnt   <= '0;
      to_cnt       <= '0;
      word_buf     <= '0;
    end else begin
      mem_we <= 1'b0;
      if (state == IDLE && load_en) begin
        word_count   <= '0;
        mem_addr     <= '0;
        err_timeout  <= 1'b0;
        err_overflow <= 1'b0;
        byte_idx     <= '0;
        marker_cnt   <= '0;
        to_cnt       <= '0;
      end else if (state != LOAD || !load_en) begin
        byte_idx <= '0;
        to_cnt   <= '0;
      end else if (rx_break) begin
        byte_idx   <= '0;
        marker_cnt <= '0;
        to_cnt     <= '0;
      end else if (rx_valid) begin
        to_cnt <= '0;
        if (word_end) begin
          byte_idx   <= '0;
          marker_cnt <= is_marker ? marker_cnt + 4'd1 : 4'd0;
          // A full memory drops the word but still counts markers so loading can end.
          if (word_count == DEPTH_CNT) begin
            err_overflow <= 1'b1;
          end else begin
            mem_we     <= 1'b1;
            mem_addr   <= word_count[ADDR_W-1:0];
            mem_wdata  <= word_full;
            word_count <= word_count + 1'b1;
          end
        end else begin
          byte_idx <= byte_idx + 1'b1;
          word_buf <= word_full;
        end
      end else if (timed_out) begin
        byte_idx    <= '0;
        to_cnt      <= '0;
        err_timeout <= 1'b1;
      end else if (busy) begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_uart_imem_loader.sv
// Bench for uart_imem_loader: a 4-byte instance (a_*) and a 1-byte instance (b_*)
// checked against a byte-level reference model and a write scoreboard.
module tb_uart_imem_loader;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        a_load_en = 1'b0, a_rx_valid = 1'b0, a_rx_break = 1'b0;
  logic [7:0]  a_rx_data = '0;
  logic        a_mem_we, a_busy, a_write_done, a_err_timeout, a_err_overflow;
  logic [7:0]  a_mem_addr;
  logic [31:0] a_mem_wdata;
  logic [8:0]  a_word_count;

  logic        b_load_en = 1'b0, b_rx_valid = 1'b0, b_rx_break = 1'b0;
  logic [7:0]  b_rx_data = '0;
  logic        b_mem_we, b_busy, b_write_done, b_err_timeout, b_err_overflow;
  logic [7:0]  b_mem_addr;
  logic [7:0]  b_mem_wdata;
  logic [8:0]  b_word_count;

  uart_imem_loader #(.NBYTES(4), .ADDR_W(8), .DEPTH(8), .END_WORD(32'hFFFF_FFFF),
                     .END_COUNT(2), .TIMEOUT(100)) dut_a (
    .clk(clk), .rst(rst), .load_en(a_load_en), .rx_valid(a_rx_valid),
    .rx_data(a_rx_data), .rx_break(a_rx_break), .mem_we(a_mem_we),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .busy(a_busy),
    .write_done(a_write_done), .word_count(a_word_count),
    .err_timeout(a_err_timeout), .err_overflow(a_err_overflow));

  uart_imem_loader #(.NBYTES(1), .ADDR_W(8), .DEPTH(4), .END_WORD(8'hFF),
                     .END_COUNT(2), .TIMEOUT(100)) dut_b (
    .clk(clk), .rst(rst), .load_en(b_load_en), .rx_valid(b_rx_valid),
    .rx_data(b_rx_data), .rx_break(b_rx_break), .mem_we(b_mem_we),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .busy(b_busy),
    .write_done(b_write_done), .word_count(b_word_count),
    .err_timeout(b_err_timeout), .err_overflow(b_err_overflow));

  logic [12:0] a_status, b_status;
  assign a_status = {a_write_done, a_busy, a_err_timeout, a_err_overflow, a_word_count};
  assign b_status = {b_write_done, b_busy, b_err_timeout, b_err_overflow, b_word_count};

  int n_cmp = 0;
  int n_bad = 0;

  // Scoreboard: expected {addr, data} of every write, in order.
  logic [39:0] exp_q_a[$];
  logic [15:0] exp_q_b[$];

  // Reference model, one slot per instance (0 = a, 1 = b).
  bit          m_loading[2];
  bit          m_done[2];
  int          m_nb[2];
  logic [63:0] m_acc[2];
  int          m_wc[2];
  int          m_run[2];
  bit          m_eto[2];
  bit          m_eovf[2];

  function automatic int nb_of(input int sel);
    return (sel == 0) ? 4 : 1;
  endfunction
  function automatic int dep_of(input int sel);
    return (sel == 0) ? 8 : 4;
  endfunction
  function automatic logic [63:0] end_of(input int sel);
    return (sel == 0) ? 64'hFFFF_FFFF : 64'hFF;
  endfunction

  function automatic void model_reset(input int sel);
    m_loading[sel] = 0; m_done[sel] = 0; m_nb[sel] = 0; m_acc[sel] = '0;
    m_wc[sel] = 0; m_run[sel] = 0; m_eto[sel] = 0; m_eovf[sel] = 0;
  endfunction

  function automatic void model_start(input int sel);
    model_reset(sel);
    m_loading[sel] = 1;
  endfunction

  function automatic void model_stop(input int sel);
    m_loading[sel] = 0; m_done[sel] = 0; m_nb[sel] = 0; m_acc[sel] = '0;
  endfunction

  function automatic void model_break(input int sel);
    if (!m_loading[sel] || m_done[sel]) return;
    m_nb[sel] = 0; m_acc[sel] = '0; m_run[sel] = 0;
  endfunction

  function automatic void model_timeout(input int sel);
    m_nb[sel] = 0; m_acc[sel] = '0; m_eto[sel] = 1;
  endfunction

  function automatic void model_byte(input int sel, input logic [7:0] b);
    logic [63:0] w;
    if (!m_loading[sel] || m_done[sel]) return;
    m_acc[sel] = m_acc[sel] | (64'(b) << (8 * m_nb[sel]));
    m_nb[sel]++;
    if (m_nb[sel] < nb_of(sel)) return;
    w = m_acc[sel];
    m_acc[sel] = '0;
    m_nb[sel] = 0;
    if (m_wc[sel] == dep_of(sel)) begin
      m_eovf[sel] = 1;
    end else begin
      if (sel == 0) exp_q_a.push_back({8'(m_wc[sel]), w[31:0]});
      else          exp_q_b.push_back({8'(m_wc[sel]), w[7:0]});
      m_wc[sel]++;
    end
    if (w == end_of(sel)) m_run[sel]++;
    else                  m_run[sel] = 0;
    if (m_run[sel] == 2) m_done[sel] = 1;
  endfunction

  function automatic logic [12:0] model_status(input int sel);
    bit busy_m;
    busy_m = m_loading[sel] && !m_done[sel] && (m_nb[sel] != 0);
    return {m_done[sel], busy_m, m_eto[sel], m_eovf[sel], 9'(m_wc[sel])};
  endfunction

  // Write monitors, sampled on the falling edge.
  always @(negedge clk) begin
    logic [39:0] e;
    if (a_mem_we === 1'b1) begin
      n_cmp++;
      if (exp_q_a.size() == 0) begin
        n_bad++;
        $display("FAIL a_write: got write addr=%0h data=%08h, required no write", a_mem_addr, a_mem_wdata);
      end else begin
        e = exp_q_a.pop_front();
        if ({a_mem_addr, a_mem_wdata} !== e) begin
          n_bad++;
          $display("FAIL a_write: got addr=%0h data=%08h, required addr=%0h data=%08h",
                   a_mem_addr, a_mem_wdata, e[39:32], e[31:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [15:0] e;
    if (b_mem_we === 1'b1) begin
      n_cmp++;
      if (exp_q_b.size() == 0) begin
        n_bad++;
        $display("FAIL b_write: got write addr=%0h data=%02h, required no write", b_mem_addr, b_mem_wdata);
      end else begin
        e = exp_q_b.pop_front();
        if ({b_mem_addr, b_mem_wdata} !== e) begin
          n_bad++;
          $display("FAIL b_write: got addr=%0h data=%02h, required addr=%0h data=%02h",
                   b_mem_addr, b_mem_wdata, e[15:8], e[7:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_cycle(input int sel, input logic v, input logic [7:0] d, input logic brk);
    if (sel == 0) begin a_rx_valid = v; a_rx_data = d; a_rx_break = brk; end
    else          begin b_rx_valid = v; b_rx_data = d; b_rx_break = brk; end
    if (brk)    model_break(sel);
    else if (v) model_byte(sel, d);
    @(posedge clk);
    #1;
    a_rx_valid = 1'b0; a_rx_break = 1'b0;
    b_rx_valid = 1'b0; b_rx_break = 1'b0;
  endtask

  task automatic send_word(input int sel, input logic [31:0] w, input int gap_max);
    for (int k = 0; k < nb_of(sel); k++) begin
      drive_cycle(sel, 1'b1, w[8*k +: 8], 1'b0);
      if (k < nb_of(sel) - 1 && gap_max > 0) idle($urandom_range(0, gap_max));
    end
  endtask

  task automatic start(input int sel);
    if (sel == 0) a_load_en = 1'b1; else b_load_en = 1'b1;
    @(posedge clk);
    #1;
    model_start(sel);
  endtask

  task automatic stop(input int sel);
    if (sel == 0) a_load_en = 1'b0; else b_load_en = 1'b0;
    @(posedge clk);
    #1;
    model_stop(sel);
  endtask

  function automatic logic [31:0] rand_plain(input int sel);
    logic [31:0] w;
    w = (sel == 0) ? $urandom : 32'($urandom_range(0, 255));
    if (64'(w) == end_of(sel)) w = 32'h13;
    return w;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    a_load_en = 1'b1; a_rx_valid = 1'b1; a_rx_data = 8'h5A;
    b_load_en = 1'b1; b_rx_valid = 1'b1; b_rx_data = 8'hA5;
    idle(3);
    a_load_en = 1'b0; a_rx_valid = 1'b0; b_load_en = 1'b0; b_rx_valid = 1'b0;
    idle(1);
    rst = 1'b0;
    model_reset(0);
    model_reset(1);
    idle(1);
    n_cmp++;
    if ({a_mem_we, a_mem_addr, a_mem_wdata, a_status} !== '0) begin
      n_bad++;
      $display("FAIL reset_a: got we=%b addr=%0h data=%08h status=%h, required all 0",
               a_mem_we, a_mem_addr, a_mem_wdata, a_status);
    end
    n_cmp++;
    if ({b_mem_we, b_mem_addr, b_mem_wdata, b_status} !== '0) begin
      n_bad++;
      $display("FAIL reset_b: got we=%b addr=%0h data=%02h status=%h, required all 0",
               b_mem_we, b_mem_addr, b_mem_wdata, b_status);
    end
  endtask

  task automatic test_single_word();
    start(0);
    drive_cycle(0, 1'b1, 8'h13, 1'b0);
    drive_cycle(0, 1'b1, 8'h01, 1'b0);
    drive_cycle(0, 1'b1, 8'h01, 1'b0);
    n_cmp++;
    if (a_mem_we !== 1'b0 || a_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL single_early: got we=%b busy=%b, required we=0 busy=1", a_mem_we, a_busy);
    end
    drive_cycle(0, 1'b1, 8'hFB, 1'b0);
    n_cmp++;
    if ({a_mem_we, a_mem_addr, a_mem_wdata, a_word_count} !== {1'b1, 8'h00, 32'hFB01_0113, 9'd1}) begin
      n_bad++;
      $display("FAIL single_write: got we=%b addr=%0h data=%08h wc=%0d, required we=1 addr=0 data=fb010113 wc=1",
               a_mem_we, a_mem_addr, a_mem_wdata, a_word_count);
    end
    idle(1);
    n_cmp++;
    if (a_mem_we !== 1'b0 || a_mem_wdata !== 32'hFB01_0113 || a_mem_addr !== 8'h00) begin
      n_bad++;
      $display("FAIL single_hold: got we=%b addr=%0h data=%08h, required we=0 addr=0 data=fb010113",
               a_mem_we, a_mem_addr, a_mem_wdata);
    end
    stop(0);
  endtask

  task automatic test_end_marker();
    start(0);
    for (int i = 0; i < 3; i++) send_word(0, rand_plain(0), 2);
    send_word(0, 32'hFFFF_FFFF, 1);
    n_cmp++;
    if (a_write_done !== 1'b0) begin
      n_bad++;
      $display("FAIL end_first_marker: got write_done=%b, required 0", a_write_done);
    end
    send_word(0, 32'hFFFF_FFFF, 0);
    n_cmp++;
    if ({a_mem_we, a_write_done, a_mem_addr} !== {1'b1, 1'b1, 8'd4}) begin
      n_bad++;
      $display("FAIL end_done: got we=%b done=%b addr=%0h, required we=1 done=1 addr=4",
               a_mem_we, a_write_done, a_mem_addr);
    end
    send_word(0, rand_plain(0), 0);
    idle(2);
    n_cmp++;
    if (a_status !== model_status(0) || exp_q_a.size() != 0) begin
      n_bad++;
      $display("FAIL end_status: got %h pending=%0d, required %h pending=0",
               a_status, exp_q_a.size(), model_status(0));
    end
    stop(0);
    n_cmp++;
    if (a_status !== model_status(0)) begin
      n_bad++;
      $display("FAIL end_idle_retain: got %h, required %h", a_status, model_status(0));
    end
  endtask

  task automatic test_marker_reset();
    start(0);
    send_word(0, 32'hFFFF_FFFF, 1);
    send_word(0, 32'h0000_0013, 1);
    send_word(0, 32'hFFFF_FFFF, 1);
    idle(2);
    n_cmp++;
    if (a_status !== model_status(0) || a_write_done !== 1'b0) begin
      n_bad++;
      $display("FAIL marker_reset: got %h, required %h", a_status, model_status(0));
    end
    stop(0);
  endtask

  task automatic test_timeout();
    start(0);
    send_word(0, rand_plain(0), 0);
    drive_cycle(0, 1'b1, 8'($urandom), 1'b0);
    idle(20);
    drive_cycle(0, 1'b1, 8'($urandom), 1'b0);
    idle(98);
    n_cmp++;
    if (a_status !== model_status(0)) begin
      n_bad++;
      $display("FAIL timeout_before: got %h, required %h", a_status, model_status(0));
    end
    idle(3);
    model_timeout(0);
    n_cmp++;
    if (a_status !== model_status(0)) begin
      n_bad++;
      $display("FAIL timeout_after: got %h, required %h", a_status, model_status(0));
    end
    send_word(0, rand_plain(0), 3);
    idle(2);
    n_cmp++;
    if (a_status !== model_status(0) || exp_q_a.size() != 0) begin
      n_bad++;
      $display("FAIL timeout_resume: got %h pending=%0d, required %h pending=0",
               a_status, exp_q_a.size(), model_status(0));
    end
    stop(0);
  endtask

  task automatic test_break();
    start(0);
    drive_cycle(0, 1'b1, 8'($urandom), 1'b0);
    drive_cycle(0, 1'b1, 8'($urandom), 1'b0);
    drive_cycle(0, 1'b0, 8'h00, 1'b1);
    send_word(0, rand_plain(0), 1);
    send_word(0, 32'hFFFF_FFFF, 0);
    drive_cycle(0, 1'b0, 8'h00, 1'b1);
    send_word(0, 32'hFFFF_FFFF, 0);
    idle(1);
    n_cmp++;
    if (a_status !== model_status(0)) begin
      n_bad++;
      $display("FAIL break_marker: got %h, required %h", a_status, model_status(0));
    end
    drive_cycle(0, 1'b1, 8'hFF, 1'b0);
    drive_cycle(0, 1'b1, 8'h77, 1'b1);
    drive_cycle(0, 1'b1, 8'hFF, 1'b0);
    drive_cycle(0, 1'b1, 8'hFF, 1'b0);
    drive_cycle(0, 1'b1, 8'hFF, 1'b0);
    idle(2);
    n_cmp++;
    if (a_status !== model_status(0) || exp_q_a.size() != 0) begin
      n_bad++;
      $display("FAIL break_with_valid: got %h pending=%0d, required %h pending=0",
               a_status, exp_q_a.size(), model_status(0));
    end
    stop(0);
  endtask

  task automatic test_overflow();
    start(0);
    for (int i = 0; i < 9; i++) send_word(0, rand_plain(0), 1);
    idle(1);
    n_cmp++;
    if (a_status !== model_status(0) || a_mem_addr !== 8'd7) begin
      n_bad++;
      $display("FAIL overflow_flag: got %h addr=%0h, required %h addr=7",
               a_status, a_mem_addr, model_status(0));
    end
    send_word(0, 32'hFFFF_FFFF, 0);
    send_word(0, 32'hFFFF_FFFF, 0);
    idle(1);
    n_cmp++;
    if (a_status !== model_status(0) || exp_q_a.size() != 0) begin
      n_bad++;
      $display("FAIL overflow_done: got %h pending=%0d, required %h pending=0",
               a_status, exp_q_a.size(), model_status(0));
    end
    rst = 1'b1;
    a_load_en = 1'b0;
    b_load_en = 1'b0;
    idle(1);
    rst = 1'b0;
    model_reset(0);
    model_reset(1);
    n_cmp++;
    if ({a_mem_we, a_mem_addr, a_mem_wdata, a_status} !== '0) begin
      n_bad++;
      $display("FAIL overflow_rst: got addr=%0h data=%08h status=%h, required all 0",
               a_mem_addr, a_mem_wdata, a_status);
    end
  endtask

  task automatic test_back_to_back();
    start(1);
    drive_cycle(1, 1'b1, 8'hAA, 1'b0);
    n_cmp++;
    if ({b_mem_we, b_mem_addr, b_mem_wdata} !== {1'b1, 8'd0, 8'hAA}) begin
      n_bad++;
      $display("FAIL b2b_first: got we=%b addr=%0h data=%02h, required we=1 addr=0 data=aa",
               b_mem_we, b_mem_addr, b_mem_wdata);
    end
    drive_cycle(1, 1'b1, 8'hBB, 1'b0);
    n_cmp++;
    if ({b_mem_we, b_mem_addr, b_mem_wdata} !== {1'b1, 8'd1, 8'hBB}) begin
      n_bad++;
      $display("FAIL b2b_second: got we=%b addr=%0h data=%02h, required we=1 addr=1 data=bb",
               b_mem_we, b_mem_addr, b_mem_wdata);
    end
    drive_cycle(1, 1'b1, 8'h55, 1'b1);
    n_cmp++;
    if (b_mem_we !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_break_drop: got we=%b, required 0", b_mem_we);
    end
    drive_cycle(1, 1'b1, 8'h33, 1'b0);
    drive_cycle(1, 1'b1, 8'h44, 1'b0);
    drive_cycle(1, 1'b1, 8'h66, 1'b0);
    idle(1);
    n_cmp++;
    if (b_status !== model_status(1) || exp_q_b.size() != 0) begin
      n_bad++;
      $display("FAIL b2b_overflow: got %h pending=%0d, required %h pending=0",
               b_status, exp_q_b.size(), model_status(1));
    end
    stop(1);
  endtask

  task automatic test_random(input int sel);
    for (int round = 0; round < 4; round++) begin
      start(sel);
      for (int ev = 0; ev < $urandom_range(3, 12); ev++) begin
        int r;
        r = $urandom_range(0, 15);
        if (r == 0) begin
          drive_cycle(sel, 1'b0, 8'h00, 1'b1);
        end else if (r == 1) begin
          for (int k = 0; k < $urandom_range(1, 3) && k < nb_of(sel) - 1; k++)
            drive_cycle(sel, 1'b1, 8'($urandom), 1'b0);
          drive_cycle(sel, $urandom_range(0, 1) == 1, 8'($urandom), 1'b1);
        end else if (r <= 4) begin
          send_word(sel, end_of(sel) == 64'hFF ? 32'hFF : 32'hFFFF_FFFF, 2);
        end else begin
          send_word(sel, $urandom, 2);
        end
        idle($urandom_range(0, 3));
      end
      idle(2);
      n_cmp++;
      if (sel == 0 ? (a_status !== model_status(0) || exp_q_a.size() != 0)
                   : (b_status !== model_status(1) || exp_q_b.size() != 0)) begin
        n_bad++;
        $display("FAIL random_%0d_round%0d: got %h, required %h",
                 sel, round, sel == 0 ? a_status : b_status, model_status(sel));
      end
      stop(sel);
      n_cmp++;
      if ((sel == 0 ? a_status : b_status) !== model_status(sel)) begin
        n_bad++;
        $display("FAIL random_%0d_idle%0d: got %h, required %h",
                 sel, round, sel == 0 ? a_status : b_status, model_status(sel));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset(0);
    model_reset(1);
    @(posedge clk);
    #1;
    test_reset();
    test_single_word();
    test_end_marker();
    test_marker_reset();
    test_timeout();
    test_break();
    test_overflow();
    test_back_to_back();
    test_random(0);
    test_random(1);
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
